// File: rtl/digit_edit_sequencer_pkg.sv
// Shared types and helpers for the digit edit sequencer: FSM state encoding,
// digit count, BCD limit, and small combinational helpers.
package digit_edit_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_STOP = 2'd1,
    ST_EDIT      = 2'd2,
    ST_WRITE     = 2'd3
  } state_e;

  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned DIGIT_W    = 2;
  localparam logic [3:0]  BCD_MAX    = 4'd9;

  // BCD increment that wraps 9 back to 0.
  function automatic logic [3:0] bcd_inc(input logic [3:0] v);
    bcd_inc = (v >= BCD_MAX) ? 4'd0 : (v + 4'd1);
  endfunction

  // One-hot mask selecting a single digit position.
  function automatic logic [NUM_DIGITS-1:0] digit_onehot(input logic [DIGIT_W-1:0] sel);
    digit_onehot = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << sel;
  endfunction

endpackage

// File: rtl/digit_edit_sequencer_button_debounce.sv
// Pushbutton debouncer: one sync flop, then a stability counter. The level
// only changes after the sampled input has disagreed with it for DB_CYCLES
// consecutive cycles; an accepted rising level gives a one-cycle press pulse.
module button_debounce #(
  parameter int unsigned DB_CYCLES = 50000
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic raw_i,
  output logic level_o,
  output logic press_o
);

  localparam int unsigned CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);

  logic          raw_q;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Count consecutive disagreeing samples and accept the new level at the limit.
  always_comb begin
    level_d = level_q;
    press_d = 1'b0;
    cnt_d   = {CW{1'b0}};
    if (raw_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = raw_q;
        press_d = raw_q;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end else begin
      cnt_d = {CW{1'b0}};
    end
  end

  // Input sampling, debounce state and registered press pulse.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      raw_q   <= 1'b0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= {CW{1'b0}};
    end else begin
      raw_q   <= raw_i;
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;
  assign press_o = press_q;

endmodule

// File: rtl/digit_edit_sequencer.sv
// Front-panel digit editor: pauses the counter chain, lets the user step a
// value into each of the four BCD digits, and issues a one-cycle active-low
// write strobe per digit. The digit under edit blinks via blank_mask_o.
module digit_edit_sequencer
  import digit_edit_sequencer_pkg::*;
#(
  parameter int unsigned DB_CYCLES      = 50000,
  parameter int unsigned BLINK_CYCLES   = 12500000,
  parameter int unsigned TIMEOUT_CYCLES = 500000000
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  mode_btn_i,
  input  logic                  up_btn_i,
  input  logic                  run_i,
  output logic                  pause_req_o,
  output logic [DIGIT_W-1:0]    digit_o,
  output logic [3:0]            wvalue_o,
  output logic                  wenable_n_o,
  output logic                  edit_active_o,
  output logic [NUM_DIGITS-1:0] blank_mask_o
);

  localparam int unsigned BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);
  localparam logic [BW-1:0] BLINK_ONE  = BW'(1'b1);
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TMO_ONE    = TW'(1'b1);
  localparam logic [DIGIT_W-1:0] DIGIT_LAST = DIGIT_W'(NUM_DIGITS - 1);

  logic mode_level_s, up_level_s, mode_press_s, up_press_s;
  logic unused_levels_s;

  button_debounce #(.DB_CYCLES(DB_CYCLES)) u_mode_db (
    .clk_i(clk_i), .reset_i(reset_i), .raw_i(mode_btn_i),
    .level_o(mode_level_s), .press_o(mode_press_s)
  );

  button_debounce #(.DB_CYCLES(DB_CYCLES)) u_up_db (
    .clk_i(clk_i), .reset_i(reset_i), .raw_i(up_btn_i),
    .level_o(up_level_s), .press_o(up_press_s)
  );

  assign unused_levels_s = mode_level_s ^ up_level_s;

  state_e              state_q, state_d;
  logic [DIGIT_W-1:0]  sel_q, sel_d;
  logic [3:0]          val_q, val_d;
  logic [TW-1:0]       tmo_q, tmo_d;
  logic [BW-1:0]       blink_cnt_q, blink_cnt_d;
  logic                blink_q, blink_d;
  logic                active_q, wen_n_q;
  logic [NUM_DIGITS-1:0] blank_q;
  logic                any_press_s;

  // Mode beats up when both land in the same cycle.
  assign any_press_s = mode_press_s | up_press_s;

  // Next-state, digit select/value and inactivity timeout.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    val_d   = val_q;
    tmo_d   = {TW{1'b0}};
    case (state_q)
      ST_IDLE: begin
        sel_d = {DIGIT_W{1'b0}};
        val_d = 4'd0;
        if (mode_press_s) begin
          state_d = run_i ? ST_WAIT_STOP : ST_EDIT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT_STOP: begin
        if (!run_i) begin
          state_d = ST_EDIT;
          sel_d   = {DIGIT_W{1'b0}};
          val_d   = 4'd0;
        end else if (any_press_s) begin
          tmo_d = {TW{1'b0}};
        end else if (tmo_q == TMO_LAST) begin
          state_d = ST_IDLE;
        end else begin
          tmo_d = tmo_q + TMO_ONE;
        end
      end
      ST_EDIT: begin
        if (mode_press_s) begin
          state_d = ST_WRITE;
        end else if (up_press_s) begin
          val_d = bcd_inc(val_q);
        end else if (tmo_q == TMO_LAST) begin
          state_d = ST_IDLE;
          sel_d   = {DIGIT_W{1'b0}};
          val_d   = 4'd0;
        end else begin
          tmo_d = tmo_q + TMO_ONE;
        end
      end
      ST_WRITE: begin
        val_d = 4'd0;
        if (sel_q == DIGIT_LAST) begin
          state_d = ST_IDLE;
          sel_d   = {DIGIT_W{1'b0}};
        end else begin
          state_d = ST_EDIT;
          sel_d   = sel_q + 2'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        sel_d   = {DIGIT_W{1'b0}};
        val_d   = 4'd0;
      end
    endcase
  end

  // Blink phase: restarts low on every entry to EDIT, toggles each half-period.
  always_comb begin
    blink_cnt_d = {BW{1'b0}};
    blink_d     = 1'b0;
    if (state_d == ST_EDIT) begin
      if (state_q != ST_EDIT) begin
        blink_cnt_d = {BW{1'b0}};
        blink_d     = 1'b0;
      end else if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d = {BW{1'b0}};
        blink_d     = ~blink_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BLINK_ONE;
        blink_d     = blink_q;
      end
    end else begin
      blink_cnt_d = {BW{1'b0}};
      blink_d     = 1'b0;
    end
  end

  // State, counters, and outputs registered from their next-state values.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= ST_IDLE;
      sel_q       <= {DIGIT_W{1'b0}};
      val_q       <= 4'd0;
      tmo_q       <= {TW{1'b0}};
      blink_cnt_q <= {BW{1'b0}};
      blink_q     <= 1'b0;
      active_q    <= 1'b0;
      wen_n_q     <= 1'b1;
      blank_q     <= {NUM_DIGITS{1'b0}};
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      val_q       <= val_d;
      tmo_q       <= tmo_d;
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
      active_q    <= (state_d != ST_IDLE);
      wen_n_q     <= (state_d != ST_WRITE);
      blank_q     <= ((state_d == ST_EDIT) && blink_d) ? digit_onehot(sel_d)
                                                       : {NUM_DIGITS{1'b0}};
    end
  end

  assign pause_req_o   = active_q;
  assign edit_active_o = active_q;
  assign wenable_n_o   = wen_n_q;
  assign digit_o       = sel_q;
  assign wvalue_o      = val_q;
  assign blank_mask_o  = blank_q;

endmodule

// File: tb/tb_digit_edit_sequencer.sv
// Directed self-checking bench for digit_edit_sequencer with small timing
// parameters. Write strobes are checked against a queue of expected writes.
module tb_digit_edit_sequencer;

  localparam int DB = 4;
  localparam int BL = 8;
  localparam int TO = 200;

  logic       clk_i = 1'b0;
  logic       reset_i, mode_btn_i, up_btn_i, run_i;
  logic       pause_req_o, wenable_n_o, edit_active_o;
  logic [1:0] digit_o;
  logic [3:0] wvalue_o, blank_mask_o;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [1:0] d;
    logic [3:0] v;
  } wr_t;
  wr_t exp_q[$];
  wr_t mon_e;
  logic prev_strobe = 1'b0;

  always #5 clk_i = ~clk_i;

  digit_edit_sequencer #(
    .DB_CYCLES(DB), .BLINK_CYCLES(BL), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i(clk_i), .reset_i(reset_i), .mode_btn_i(mode_btn_i),
    .up_btn_i(up_btn_i), .run_i(run_i), .pause_req_o(pause_req_o),
    .digit_o(digit_o), .wvalue_o(wvalue_o), .wenable_n_o(wenable_n_o),
    .edit_active_o(edit_active_o), .blank_mask_o(blank_mask_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic push_wr(input logic [1:0] d, input logic [3:0] v);
    exp_q.push_back({d, v});
  endtask

  task automatic press_btn(input logic m, input logic u);
    mode_btn_i = m;
    up_btn_i   = u;
    tick(8);
    mode_btn_i = 1'b0;
    up_btn_i   = 1'b0;
    tick(8);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pause"}, pause_req_o, 0);
    check({tag, "_active"}, edit_active_o, 0);
    check({tag, "_wen_n"}, wenable_n_o, 1);
    check({tag, "_digit"}, digit_o, 0);
    check({tag, "_wvalue"}, wvalue_o, 0);
    check({tag, "_blank"}, blank_mask_o, 0);
  endtask

  // Strobe monitor: every low wenable_n_o must match the next expected write.
  always @(negedge clk_i) begin
    if (wenable_n_o === 1'b0) begin
      check("strobe_one_cycle", prev_strobe, 0);
      check("strobe_expected", (exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        check("strobe_digit", digit_o, mon_e.d);
        check("strobe_value", wvalue_o, mon_e.v);
      end
    end
    prev_strobe = (wenable_n_o === 1'b0);
  end

  // Global watchdog so the run always ends.
  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic ok;
    reset_i    = 1'b1;
    mode_btn_i = 1'b0;
    up_btn_i   = 1'b0;
    run_i      = 1'b0;
    tick(3);
    check_reset_outputs("reset");
    reset_i = 1'b0;
    tick(2);
    check_reset_outputs("after_reset");

    // Debounce: short glitch ignored.
    mode_btn_i = 1'b1;
    tick(2);
    mode_btn_i = 1'b0;
    tick(10);
    check("glitch_no_edit", edit_active_o, 0);

    // Debounce: 10-cycle hold, latency DB+2 to edit_active_o.
    mode_btn_i = 1'b1;
    tick(DB + 1);
    check("db_not_yet", edit_active_o, 0);
    tick(1);
    check("db_latency", edit_active_o, 1);
    check("db_pause", pause_req_o, 1);
    tick(10 - (DB + 2));
    mode_btn_i = 1'b0;
    tick(10);
    check("db_single_press", edit_active_o, 1);
    check("db_digit0", digit_o, 0);

    // Full edit with run_i=0.
    repeat (3) press_btn(1'b0, 1'b1);
    check("edit_val3", wvalue_o, 3);
    push_wr(2'd0, 4'd3);
    press_btn(1'b1, 1'b0);
    check("edit_sel1", digit_o, 1);
    repeat (10) press_btn(1'b0, 1'b1);
    check("edit_wrap", wvalue_o, 0);
    push_wr(2'd1, 4'd0);
    press_btn(1'b1, 1'b0);
    repeat (9) press_btn(1'b0, 1'b1);
    check("edit_val9", wvalue_o, 9);
    push_wr(2'd2, 4'd9);
    press_btn(1'b1, 1'b0);
    push_wr(2'd3, 4'd0);
    press_btn(1'b1, 1'b0);
    check("full_all_written", exp_q.size(), 0);
    check_reset_outputs("full_done");

    // Running start: WAIT_STOP holds while run_i=1.
    run_i = 1'b1;
    tick(2);
    press_btn(1'b1, 1'b0);
    check("wait_active", edit_active_o, 1);
    check("wait_pause", pause_req_o, 1);
    ok = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick(1);
      if (edit_active_o !== 1'b1 || pause_req_o !== 1'b1 || blank_mask_o !== 4'd0) ok = 1'b0;
    end
    check("wait_hold50", ok, 1);
    run_i = 1'b0;
    tick(BL);
    check("edit_entry_blank_low", blank_mask_o, 0);
    tick(1);
    check("edit_entry_blank_high", blank_mask_o, 4'b0001);

    // Move to digit 1, then let it time out while watching the blink.
    push_wr(2'd0, 4'd0);
    mode_btn_i = 1'b1;
    n = 0;
    do begin
      tick(1);
      n++;
    end while (wenable_n_o !== 1'b0 && n < 40);
    check("tmo_strobe_seen", wenable_n_o, 0);
    mode_btn_i = 1'b0;
    n = 0;
    do begin
      tick(1);
      n++;
      if (edit_active_o === 1'b1 && n <= 4 * BL)
        check("blink", blank_mask_o, ((((n - 1) / BL) % 2) != 0) ? 32'h2 : 32'h0);
    end while (edit_active_o === 1'b1 && n < 2 * TO);
    check("timeout_cycles", n, TO + 1);
    check_reset_outputs("timeout");

    // Simultaneous mode+up in EDIT with val=5 writes 5.
    press_btn(1'b1, 1'b0);
    repeat (5) press_btn(1'b0, 1'b1);
    check("simul_val5", wvalue_o, 5);
    push_wr(2'd0, 4'd5);
    press_btn(1'b1, 1'b1);
    check("simul_next_digit", digit_o, 1);
    check("simul_val_cleared", wvalue_o, 0);
    check("simul_active", edit_active_o, 1);

    // Reset one cycle before WRITE would be entered.
    mode_btn_i = 1'b1;
    tick(DB + 1);
    reset_i = 1'b1;
    tick(1);
    mode_btn_i = 1'b0;
    tick(1);
    check_reset_outputs("midreset");
    reset_i = 1'b0;
    tick(20);
    check_reset_outputs("midreset_after");

    check("all_strobes_seen", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
